// File: rtl/sum_avg_divider_pkg.sv
// Shared constants for the five-operand adder / average divider chain:
// operand, sum and remainder widths, the divisor, and the FSM encoding.
package sum_avg_divider_pkg;

  localparam int N_OPS = 5;
  localparam int OP_W  = 4;
  localparam int SUM_W = 6;
  localparam int REM_W = 3;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SUB  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Largest quotient representable in w bits; results beyond it saturate.
  function automatic int sat_limit(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/sum_avg_divider_sub_const_stage.sv
// Combinational compare-and-subtract of a W-bit unsigned value against
// the constant divisor. The caller uses diff only when ge is set, so the
// subtraction never underflows in practice.
module sub_const_stage #(
  parameter int W     = 7,
  parameter int N_OPS = 5
) (
  input  logic [W-1:0] a,
  output logic         ge,
  output logic [W-1:0] diff
);

  localparam logic [W-1:0] N_VAL = W'(N_OPS);

  assign ge   = (a >= N_VAL);
  assign diff = a - N_VAL;

endmodule

// File: rtl/sum_avg_divider.sv
// Sequential divide-by-N_OPS unit: recovers the per-operand average and
// remainder from the five-operand adder's {carry_out, sum} by repeated
// subtraction. The quotient saturates at 2^OP_W-1 and flags ovf.
module sum_avg_divider
  import sum_avg_divider_pkg::*;
#(
  parameter int N_OPS = sum_avg_divider_pkg::N_OPS,
  parameter int OP_W  = sum_avg_divider_pkg::OP_W,
  parameter int SUM_W = sum_avg_divider_pkg::SUM_W,
  parameter int REM_W = sum_avg_divider_pkg::REM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SUM_W-1:0] sum,
  input  logic             carry_in,
  output logic [OP_W-1:0]  quotient,
  output logic [REM_W-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam logic [OP_W-1:0] CNT_MAX = OP_W'(sat_limit(OP_W));

  logic [1:0]       state;
  logic [SUM_W:0]   work;
  logic [OP_W-1:0]  cnt;
  logic             work_ge;
  logic [SUM_W:0]   work_diff;
  logic [SUM_W:0]   dividend;

  assign dividend = {carry_in, sum};

  sub_const_stage #(
    .W     (SUM_W + 1),
    .N_OPS (N_OPS)
  ) u_sub (
    .a    (work),
    .ge   (work_ge),
    .diff (work_diff)
  );

  // Control: state sequencing plus registered busy/done decodes of the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SUB;
            busy  <= 1'b1;
          end
        end
        ST_SUB: begin
          busy <= 1'b1;
          if (!work_ge || (cnt == CNT_MAX)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: capture dividend, iterate subtraction, publish results on SUB->DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            work <= dividend;
            cnt  <= '0;
          end
        end
        ST_SUB: begin
          if (!work_ge) begin
            quotient  <= cnt;
            remainder <= work[REM_W-1:0];
            ovf       <= 1'b0;
          end else if (cnt != CNT_MAX) begin
            work <= work_diff;
            cnt  <= cnt + 1'b1;
          end else begin
            quotient  <= CNT_MAX;
            remainder <= '0;
            ovf       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_avg_divider.sv
// Self-checking bench for sum_avg_divider: table of single operations with
// expected results and done latency, plus hand-written corner sequences
// (start ignored while busy, asynchronous reset mid-operation, back-to-back).
module tb_sum_avg_divider;

  logic       clk;
  logic       reset;
  logic       start;
  logic [5:0] sum;
  logic       carry_in;
  logic [3:0] quotient;
  logic [2:0] remainder;
  logic       busy;
  logic       done;
  logic       ovf;

  sum_avg_divider dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sum       (sum),
    .carry_in  (carry_in),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] s;
    logic       c;
    int         q;
    int         r;
    int         o;
    int         e;
  } vec_t;

  typedef struct {
    int q;
    int r;
    int o;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   checks;
  int   failures;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the current outputs.
  task automatic score(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, " unexpected done"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({name, " quotient"}, int'(quotient), e.q);
      chk({name, " remainder"}, int'(remainder), e.r);
      chk({name, " ovf"}, int'(ovf), e.o);
    end
  endtask

  // Start one operation, wait (bounded) for done, check latency and results.
  task automatic run_op(input string name, input logic [5:0] s, input logic c,
                        input int q, input int r, input int o, input int e);
    exp_t x;
    int   n;
    int   busy_bad;
    bit   got;
    @(negedge clk);
    sum = s; carry_in = c; start = 1'b1;
    x.q = q; x.r = r; x.o = o;
    sb.push_back(x);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; got = 1'b0; busy_bad = 0;
    if (busy !== 1'b1) busy_bad++;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) got = 1'b1;
    end
    if (!got) begin
      chk({name, " timeout"}, 0, 1);
    end else begin
      chk({name, " latency"}, n, e);
      chk({name, " busy during op"}, busy_bad, 0);
      score(name);
      @(posedge clk); #1;
      chk({name, " done single"}, int'(done), 0);
      chk({name, " busy after"}, int'(busy), 0);
    end
  endtask

  initial begin
    int   n;
    int   dones;
    int   k;
    exp_t x;

    checks = 0; failures = 0;
    start = 1'b0; sum = '0; carry_in = 1'b0;

    vecs[0] = '{6'd37, 1'b0,  7, 2, 0,  8};
    vecs[1] = '{6'd0,  1'b0,  0, 0, 0,  1};
    vecs[2] = '{6'd11, 1'b1, 15, 0, 0, 16};
    vecs[3] = '{6'd36, 1'b1, 15, 0, 1, 16};
    vecs[4] = '{6'd14, 1'b0,  2, 4, 0,  3};
    vecs[5] = '{6'd9,  1'b0,  1, 4, 0,  2};
    vecs[6] = '{6'd63, 1'b1, 15, 0, 1, 16};
    vecs[7] = '{6'd4,  1'b0,  0, 4, 0,  1};
    vecs[8] = '{6'd37, 1'b0,  7, 2, 0,  8};

    // Reset state
    reset = 1'b1;
    #1;
    chk("reset quotient", int'(quotient), 0);
    chk("reset remainder", int'(remainder), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset ovf", int'(ovf), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven single operations
    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].c,
             vecs[i].q, vecs[i].r, vecs[i].o, vecs[i].e);
    end

    // Start while busy is ignored; operand changes mid-op are ignored
    @(negedge clk);
    sum = 6'd37; carry_in = 1'b0; start = 1'b1;
    x.q = 7; x.r = 2; x.o = 0;
    sb.push_back(x);
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (n = 1; n <= 14; n++) begin
      if (n == 3) begin
        sum = 6'd10; start = 1'b1;
      end
      @(posedge clk); #1;
      if (n == 3) begin
        start = 1'b0; sum = 6'd50;
      end
      if (done === 1'b1) begin
        dones++;
        chk("ignore-start latency", n, 8);
        score("ignore-start");
      end
    end
    chk("ignore-start done count", dones, 1);
    chk("ignore-start queue empty", sb.size(), 0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    sum = 6'd60; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async reset quotient", int'(quotient), 0);
    chk("async reset remainder", int'(remainder), 0);
    chk("async reset busy", int'(busy), 0);
    chk("async reset ovf", int'(ovf), 0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    chk("post-reset no done", dones, 0);
    chk("post-reset idle", int'(busy), 0);
    run_op("after-reset", 6'd9, 1'b0, 1, 4, 0, 2);

    // Start held high: back-to-back operations, done every 4 cycles
    @(negedge clk);
    sum = 6'd5; carry_in = 1'b0; start = 1'b1;
    x.q = 1; x.r = 0; x.o = 0;
    for (int i = 0; i < 4; i++) sb.push_back(x);
    @(posedge clk); #1;
    k = 0;
    for (n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 12) start = 1'b0;
      if (done === 1'b1) begin
        chk($sformatf("b2b done edge %0d", k), n, 2 + 4 * k);
        score("b2b");
        k++;
      end
    end
    chk("b2b done count", k, 4);
    chk("b2b queue empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
